sd_clk_gen: RTL and testbench
=============================

Name: sd_clk_gen

Overview:
- Parametrised SD-bus clock generator for the SD host controller; successor to the fixed toggle divider.
- Divides clk by a runtime-programmable even ratio and drives sd_clk for the card interface.
- Adds stop/start gating that never truncates a high phase, and glitch-free divisor changes applied only at falling-edge boundaries.
- Emits single-cycle rise/fall strobes for the command/data engines (drive on fall, sample on rise), plus running and stable status.

Parameters:
- WIDTH, 16, divisor and counter width in bits.
- DEFAULT_DIV, 16'd124, divisor loaded at reset; half-period = DEFAULT_DIV+1 clk cycles (400 kHz identification rate from 100 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- clk_en  in  1  level request: 1 = run sd_clk, 0 = stop sd_clk low.
- div_load  in  1  one-cycle pulse; captures div_in.
- div_in  in  WIDTH  new divisor; half-period = div_in+1 cycles.
- sd_clk  out  1  divided card clock, registered.
- rise_stb  out  1  high for exactly the clk cycle in which sd_clk first reads 1 after a 0->1 toggle.
- fall_stb  out  1  high for exactly the clk cycle in which sd_clk first reads 0 after a 1->0 toggle.
- running  out  1  high while FSM in RUN or STOPPING.
- clk_stable  out  1  high when running and no divisor update pending.

Behaviour:
- Reset (reset==0 at posedge) overrides all other inputs, including mid-phase:
  - sd_clk=0, rise_stb=0, fall_stb=0, running=0, clk_stable=0.
  - counter=0, div_q=DEFAULT_DIV, pend_v=0, state=STOPPED.
- Counting: in RUN/STOPPING, counter increments each cycle. When counter==div_q, sd_clk toggles and counter returns to 0. Width arithmetic is WIDTH-bit unsigned; div_q=0 gives clk/2.
- FSM states: STOPPED, RUN, STOPPING.
  - STOPPED -> RUN when clk_en=1. Counter starts at 0 in the first RUN cycle; the first rise occurs after div_q+1 cycles.
  - RUN -> STOPPING when clk_en=0 and sd_clk=1. The current high phase completes in full.
  - RUN -> STOPPED when clk_en=0 and sd_clk=0. Stops immediately with no toggle; counter cleared.
  - STOPPING -> STOPPED at the falling toggle (fall_stb is still issued).
  - STOPPING -> RUN when clk_en returns to 1 before the fall; no gap is inserted.
- Divisor update:
  - div_load captures div_in into pend (pend_v=1). A later div_load before application overwrites pend.
  - A pending value is applied to div_q only:
    - at a 1->0 toggle cycle (new low phase uses the new value), or
    - in any cycle while STOPPED.
  - If div_load coincides with the applying cycle, div_in is applied directly and pend_v stays 0.
  - Both halves of any period always use the same div_q; never a short high phase.
- clk_stable = running & ~pend_v, registered.
- Strobes are mutually exclusive, never asserted while STOPPED, and never asserted in consecutive cycles unless div_q=0.

Decomposition:
- Shared package sd_pkg holds:
  - the state enumeration (STOPPED, RUN, STOPPING);
  - SD_DIV_INIT (124) and SD_DIV_FAST (0) constants;
  - the default WIDTH constant.
- Single flat module; no sub-module warranted.

Test Plan:
- Reset release with clk_en=1, div stays 124 -> sd_clk first reads 1 at the 126th clk after reset deasserts (RUN entry at first cycle, then 125 cycles); period 250; rise_stb/fall_stb single-cycle pulses aligned to sd_clk edges.
- div_load div_in=1 mid high phase (div_q=4) -> current high lasts 5 cycles; following low and all later phases are 2 cycles; clk_stable low from load until that fall.
- clk_en dropped 1 cycle into a 5-cycle high phase -> high holds 4 more cycles; fall_stb fires; sd_clk then stays 0; running=0 the following cycle.
- clk_en dropped then raised before the fall (STOPPING -> RUN) -> waveform identical to uninterrupted clk_en=1.
- div_in=0, clk_en=1 -> sd_clk = clk/2; rise_stb and fall_stb alternate every cycle.
- reset asserted 2 cycles into a high phase -> next cycle sd_clk=0, all outputs 0, div_q back to 124, pending update discarded.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD card clock generator.
// Holds the generator FSM encoding, the identification-rate and fastest
// divisor constants, and the default divisor/counter width.
package sd_pkg;

  localparam int SD_WIDTH = 16;

  // Half-period = div + 1 clk cycles.
  localparam int SD_DIV_INIT = 124;  // 400 kHz from 100 MHz
  localparam int SD_DIV_FAST = 0;    // clk/2

  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } sd_state_t;

endpackage

// File: rtl/sd_clk_gen.sv
// SD card clock generator: divides clk by an even runtime ratio with glitch-free gating.
// Latency: sd_clk/strobes/status registered; first rise div_q+1 cycles after RUN entry.
// Backpressure: none; clk_en is a level request honoured only at phase boundaries.
//
// Ports:
//   clk, reset      system clock, synchronous active-low reset
//   clk_en          1 = run sd_clk, 0 = park sd_clk low (high phase always completes)
//   div_load/div_in one-cycle load of a new divisor (half-period = div_in+1 clk cycles)
//   sd_clk          divided card clock
//   rise_stb        first cycle sd_clk reads 1 after a rising toggle
//   fall_stb        first cycle sd_clk reads 0 after a falling toggle
//   running         FSM in RUN or STOPPING
//   clk_stable      running with no divisor update pending
module sd_clk_gen
  import sd_pkg::*;
#(
  parameter int               WIDTH       = SD_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(SD_DIV_INIT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             sd_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             running,
  output logic             clk_stable
);

  sd_state_t        state, state_nx;
  logic [WIDTH-1:0] counter, counter_nx;
  logic [WIDTH-1:0] div_q, div_q_nx;
  logic [WIDTH-1:0] pend, pend_nx;
  logic             pend_v, pend_v_nx;
  logic             stop_now;
  logic             toggle;
  logic             apply;

  always_comb begin
    // Stopping from a low phase is immediate and must not toggle, even if the
    // counter happens to be at its terminal value.
    stop_now = (state == RUN) && !clk_en && !sd_clk;
    toggle   = (state != STOPPED) && !stop_now && (counter == div_q);

    // Divisor changes land only where a fresh low phase starts (so both halves
    // of every period share one divisor) or while the clock is parked.
    apply = (state == STOPPED) || (toggle && sd_clk);

    state_nx = state;
    unique case (state)
      STOPPED:  state_nx = clk_en ? RUN : STOPPED;
      RUN: begin
        if (clk_en)            state_nx = RUN;
        else if (!sd_clk)      state_nx = STOPPED;
        else if (toggle)       state_nx = STOPPED;   // high phase ends this very cycle
        else                   state_nx = STOPPING;
      end
      STOPPING: begin
        if (clk_en)            state_nx = RUN;       // resume seamlessly, no gap
        else if (toggle)       state_nx = STOPPED;
        else                   state_nx = STOPPING;
      end
      default:                 state_nx = STOPPED;
    endcase

    if ((state == STOPPED) || stop_now || toggle) counter_nx = '0;
    else                                          counter_nx = counter + 1'b1;

    div_q_nx  = div_q;
    pend_nx   = pend;
    pend_v_nx = pend_v;
    if (apply) begin
      // A load coinciding with the apply point bypasses the pending register.
      if (div_load) begin
        div_q_nx  = div_in;
        pend_v_nx = 1'b0;
      end else if (pend_v) begin
        div_q_nx  = pend;
        pend_v_nx = 1'b0;
      end
    end else if (div_load) begin
      pend_nx   = div_in;
      pend_v_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= STOPPED;
      counter    <= '0;
      div_q      <= DEFAULT_DIV;
      pend       <= '0;
      pend_v     <= 1'b0;
      sd_clk     <= 1'b0;
      rise_stb   <= 1'b0;
      fall_stb   <= 1'b0;
      running    <= 1'b0;
      clk_stable <= 1'b0;
    end else begin
      state      <= state_nx;
      counter    <= counter_nx;
      div_q      <= div_q_nx;
      pend       <= pend_nx;
      pend_v     <= pend_v_nx;
      sd_clk     <= sd_clk ^ toggle;
      rise_stb   <= toggle && !sd_clk;
      fall_stb   <= toggle && sd_clk;
      running    <= (state_nx != STOPPED);
      clk_stable <= (state_nx != STOPPED) && !pend_v_nx;
    end
  end

endmodule

// File: tb/tb_sd_clk_gen.sv
// Directed bench for sd_clk_gen: phase lengths, gating, divisor updates, reset.
module tb_sd_clk_gen;
  import sd_pkg::*;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        div_load;
  logic [15:0] div_in;
  logic        sd_clk;
  logic        rise_stb;
  logic        fall_stb;
  logic        running;
  logic        clk_stable;

  int errors = 0;
  int checks = 0;
  int n;

  sd_clk_gen #(.WIDTH(16), .DEFAULT_DIV(16'd124)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .div_load   (div_load),
    .div_in     (div_in),
    .sd_clk     (sd_clk),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .running    (running),
    .clk_stable (clk_stable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Ticks until sd_clk leaves level lvl; returns tick count (bounded).
  task automatic wait_change(input logic lvl, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (sd_clk == lvl && cnt < 1000);
  endtask

  task automatic wait_level(input logic lvl);
    int c;
    c = 0;
    while (sd_clk != lvl && c < 1000) begin
      tick();
      c++;
    end
  endtask

  task automatic load_div(input logic [15:0] d);
    div_in   = d;
    div_load = 1'b1;
    tick();
    div_load = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clk_en = 1'b0; div_load = 1'b0; div_in = '0;
    tick(); tick();
    chk("rst_sd_clk", sd_clk, 0);
    chk("rst_rise", rise_stb, 0);
    chk("rst_fall", fall_stb, 0);
    chk("rst_running", running, 0);
    chk("rst_stable", clk_stable, 0);

    // Default divisor: rise at 126th clk after release, 125-cycle phases.
    reset = 1'b1; clk_en = 1'b1;
    wait_change(1'b0, n);
    chk("first_rise_cycles", n, 126);
    chk("first_rise_stb", rise_stb, 1);
    chk("first_running", running, 1);
    chk("first_stable", clk_stable, 1);
    // Divisor update requested at the start of a high phase.
    load_div(16'd4);
    chk("rise_stb_single", rise_stb, 0);
    chk("stable_pending", clk_stable, 0);
    wait_change(1'b1, n);
    chk("high_default", n, 124);
    chk("fall_stb_default", fall_stb, 1);
    chk("stable_after_apply", clk_stable, 1);
    wait_change(1'b0, n);
    chk("low_div4", n, 5);
    // Load div=1 mid high phase: current high completes at 5 cycles.
    tick(); tick();
    load_div(16'd1);
    chk("stable_pending2", clk_stable, 0);
    wait_change(1'b1, n);
    chk("high_rest_div4", n, 2);
    chk("stable_after_apply2", clk_stable, 1);
    wait_change(1'b0, n);
    chk("low_div1", n, 2);
    wait_change(1'b1, n);
    chk("high_div1", n, 2);

    // Back to div=4, then drop clk_en one cycle into a high phase.
    load_div(16'd4);
    wait_level(1'b1);
    wait_level(1'b0);
    wait_change(1'b0, n);
    chk("low_div4_b", n, 5);
    clk_en = 1'b0;
    wait_change(1'b1, n);
    chk("stop_high_len", n, 5);
    chk("stop_fall_stb", fall_stb, 1);
    tick();
    chk("stop_running", running, 0);
    chk("stop_sd_clk", sd_clk, 0);
    repeat (10) tick();
    chk("parked_sd_clk", sd_clk, 0);
    chk("parked_rise", rise_stb, 0);

    // Restart, then a brief clk_en drop in the high phase must not disturb it.
    clk_en = 1'b1;
    wait_change(1'b0, n);
    chk("restart_rise", n, 6);
    clk_en = 1'b0;
    tick();
    clk_en = 1'b1;
    wait_change(1'b1, n);
    chk("resume_high_rest", n, 4);
    chk("resume_running", running, 1);
    wait_change(1'b0, n);
    chk("resume_low", n, 5);
    wait_change(1'b1, n);
    chk("resume_high", n, 5);

    // Fastest divisor: clk/2 with alternating strobes.
    load_div(16'(SD_DIV_FAST));
    wait_level(1'b1);
    wait_level(1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fast_sd_clk", sd_clk, (i % 2 == 0) ? 1 : 0);
      chk("fast_rise", rise_stb, (i % 2 == 0) ? 1 : 0);
      chk("fast_fall", fall_stb, (i % 2 == 0) ? 0 : 1);
    end

    // Reset 2 cycles into a high phase with an update pending.
    load_div(16'd4);
    wait_level(1'b1);
    wait_level(1'b0);
    wait_change(1'b0, n);
    chk("pre_reset_low", n, 5);
    tick();
    div_in = 16'd7; div_load = 1'b1;
    tick();
    div_load = 1'b0; reset = 1'b0;
    tick();
    chk("mid_rst_sd_clk", sd_clk, 0);
    chk("mid_rst_rise", rise_stb, 0);
    chk("mid_rst_fall", fall_stb, 0);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_stable", clk_stable, 0);
    reset = 1'b1;
    wait_change(1'b0, n);
    chk("post_rst_rise", n, 126);
    chk("post_rst_stable", clk_stable, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
